// File: rtl/mod_seq_pkg.sv
// mod_seq_pkg: shared types for the modulation sequencer.
//   SEQ_PERIOD_W / SEQ_DWELL_W : default half-period and dwell widths
//   seq_state_t                : sequencer FSM states
//   seq_entry_t                : one table entry {half_period, dwell}
package mod_seq_pkg;

    localparam int SEQ_PERIOD_W = 16;
    localparam int SEQ_DWELL_W  = 24;

    typedef enum logic [1:0] {
        IDLE,
        LOAD,
        DWELL
    } seq_state_t;

    typedef struct packed {
        logic [SEQ_PERIOD_W-1:0] half_period;
        logic [SEQ_DWELL_W-1:0]  dwell;
    } seq_entry_t;

endpackage

// File: rtl/mod_seq_if.sv
// mod_seq_if: host-side table write channel of the sequencer.
//   valid/ready        : write handshake (write on valid & ready)
//   addr               : table index
//   half_period, dwell : entry payload
//   master = host side, slave = sequencer side
interface mod_seq_if #(
    parameter int DEPTH    = 8,
    parameter int PERIOD_W = 16,
    parameter int DWELL_W  = 24
);
    localparam int AW = $clog2(DEPTH);

    logic                valid;
    logic                ready;
    logic [AW-1:0]       addr;
    logic [PERIOD_W-1:0] half_period;
    logic [DWELL_W-1:0]  dwell;

    modport master (output valid, addr, half_period, dwell, input ready);
    modport slave  (input valid, addr, half_period, dwell, output ready);
endinterface

// File: rtl/mod_seq_table.sv
// mod_seq_table: DEPTH x seq_entry_t register file.
//   clk          : clock
//   we/waddr/wdata : synchronous write port
//   raddr/rdata    : asynchronous read port
// Contents are deliberately not reset.
module mod_seq_table
    import mod_seq_pkg::*;
#(
    parameter int DEPTH = 8,
    localparam int AW = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  seq_entry_t    wdata,
    input  logic [AW-1:0] raddr,
    output seq_entry_t    rdata
);
    seq_entry_t mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) mem[waddr] <= wdata;
    end

    assign rdata = mem[raddr];
endmodule

// File: rtl/mod_sequencer.sv
// mod_sequencer: steps the modulation block through a table of
// half-period values, each held for its own dwell time.
//   clk, rst (sync, active low)
//   cfg              : table write channel (ready only in IDLE)
//   seq_len/loop_mode/start/stop : sweep control, sampled on start
//   busy, done, step_idx         : status
//   mod_half_period/mod_set/mod_enable : to the modulation block
// Build option MOD_SEQ_PINGPONG_EN: looping sweeps bounce 0..len-1..0
// instead of wrapping len-1 -> 0.
// PERIOD_W/DWELL_W must match the widths of seq_entry_t.
module mod_sequencer
    import mod_seq_pkg::*;
#(
    parameter int DEPTH    = 8,
    parameter int PERIOD_W = SEQ_PERIOD_W,
    parameter int DWELL_W  = SEQ_DWELL_W,
    localparam int IW = $clog2(DEPTH),
    localparam int LW = IW + 1
) (
    input  logic                clk,
    input  logic                rst,
    mod_seq_if.slave            cfg,
    input  logic [LW-1:0]       seq_len,
    input  logic                loop_mode,
    input  logic                start,
    input  logic                stop,
    output logic                busy,
    output logic                done,
    output logic [IW-1:0]       step_idx,
    output logic [PERIOD_W-1:0] mod_half_period,
    output logic                mod_set,
    output logic                mod_enable
);
    seq_state_t         state, nxt;
    logic [LW-1:0]      len_q;
    logic               loop_q;
    logic [IW-1:0]      idx, nidx;
    logic [DWELL_W-1:0] cnt;
    logic               start_ok, last, wr, cnt_zero;
    seq_entry_t         wr_ent, rd_ent;

    assign cfg.ready = (state == IDLE) && !stop;
    assign wr        = cfg.valid && cfg.ready;
    assign busy      = (state != IDLE);
    assign step_idx  = idx;
    assign start_ok  = start && (seq_len != '0) && (seq_len <= LW'(DEPTH));
    assign last      = ({1'b0, idx} == (len_q - LW'(1)));
    assign cnt_zero  = (cnt == '0);

    assign wr_ent.half_period = cfg.half_period;
    assign wr_ent.dwell       = cfg.dwell;

    mod_seq_table #(.DEPTH(DEPTH)) u_table (
        .clk   (clk),
        .we    (wr),
        .waddr (cfg.addr),
        .wdata (wr_ent),
        .raddr (idx),
        .rdata (rd_ent)
    );

    // next step index
`ifdef MOD_SEQ_PINGPONG_EN
    logic dir, ndir;  // 0 = counting up, 1 = counting down

    always_comb begin
        nidx = last ? '0 : idx + IW'(1);
        ndir = dir;
        if (loop_q && len_q != LW'(1)) begin
            if (!dir) begin
                if (last) begin
                    nidx = idx - IW'(1);
                    ndir = 1'b1;
                end
            end else if (idx == '0) begin
                nidx = IW'(1);
                ndir = 1'b0;
            end else begin
                nidx = idx - IW'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst || stop || state == IDLE) dir <= 1'b0;
        else if (state == DWELL && cnt_zero) dir <= ndir;
    end
`else
    always_comb begin
        nidx = last ? '0 : idx + IW'(1);
    end
`endif

    always_ff @(posedge clk) begin
        if (!rst) state <= IDLE;
        else      state <= nxt;
    end

    always_comb begin
        nxt = state;
        unique case (state)
            IDLE:    if (start_ok) nxt = LOAD;
            LOAD:    nxt = DWELL;
            DWELL:   if (cnt_zero) nxt = (last && !loop_q) ? IDLE : LOAD;
            default: nxt = IDLE;
        endcase
        if (stop) nxt = IDLE;
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            len_q           <= '0;
            loop_q          <= 1'b0;
            idx             <= '0;
            cnt             <= '0;
            done            <= 1'b0;
            mod_half_period <= '0;
            mod_set         <= 1'b0;
            mod_enable      <= 1'b0;
        end else begin
            done    <= 1'b0;
            mod_set <= 1'b0;
            if (stop) begin
                idx        <= '0;
                mod_enable <= 1'b0;
            end else begin
                unique case (state)
                    IDLE: if (start_ok) begin
                        len_q  <= seq_len;
                        loop_q <= loop_mode;
                        idx    <= '0;
                    end
                    LOAD: begin
                        mod_half_period <= rd_ent.half_period;
                        mod_set         <= 1'b1;
                        mod_enable      <= 1'b1;
                        // zero dwell behaves as one cycle
                        cnt <= (rd_ent.dwell == '0) ? '0 : rd_ent.dwell - DWELL_W'(1);
                    end
                    DWELL: begin
                        if (!cnt_zero) begin
                            cnt <= cnt - DWELL_W'(1);
                        end else if (last && !loop_q) begin
                            done       <= 1'b1;
                            mod_enable <= 1'b0;
                            idx        <= '0;
                        end else begin
                            idx <= nidx;
                        end
                    end
                    default: ;
                endcase
            end
        end
    end
endmodule

// File: tb/tb_mod_sequencer.sv
// tb_mod_sequencer: directed self-checking bench for mod_sequencer.
module tb_mod_sequencer;
    localparam int DEPTH = 8;
    localparam int PW    = 16;
    localparam int DW    = 24;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic [3:0]    seq_len = '0;
    logic          loop_mode = 1'b0;
    logic          start = 1'b0;
    logic          stop = 1'b0;
    logic          busy, done, mod_set, mod_enable;
    logic [2:0]    step_idx;
    logic [PW-1:0] mod_half_period;

    int n_chk  = 0;
    int n_pass = 0;

    mod_seq_if #(.DEPTH(DEPTH), .PERIOD_W(PW), .DWELL_W(DW)) cfg_bus ();

    mod_sequencer #(.DEPTH(DEPTH), .PERIOD_W(PW), .DWELL_W(DW)) dut (
        .clk             (clk),
        .rst             (rst),
        .cfg             (cfg_bus),
        .seq_len         (seq_len),
        .loop_mode       (loop_mode),
        .start           (start),
        .stop            (stop),
        .busy            (busy),
        .done            (done),
        .step_idx        (step_idx),
        .mod_half_period (mod_half_period),
        .mod_set         (mod_set),
        .mod_enable      (mod_enable)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
    endtask

    task automatic cfg_wr(input int a, input int hp, input int d);
        cfg_bus.valid       = 1'b1;
        cfg_bus.addr        = 3'(a);
        cfg_bus.half_period = PW'(hp);
        cfg_bus.dwell       = DW'(d);
        tick();
        cfg_bus.valid = 1'b0;
    endtask

    task automatic kick(input int len, input logic lp);
        seq_len   = 4'(len);
        loop_mode = lp;
        start     = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic chk_zero(input string pfx);
        chk({pfx, "_busy"}, busy, 0);
        chk({pfx, "_done"}, done, 0);
        chk({pfx, "_idx"}, step_idx, 0);
        chk({pfx, "_hp"}, mod_half_period, 0);
        chk({pfx, "_set"}, mod_set, 0);
        chk({pfx, "_en"}, mod_enable, 0);
        chk({pfx, "_rdy"}, cfg_bus.ready, 1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int nset;
        int seen1;
        int hp2;
        int saw_done;
        int hp_exp [4];
        int idx_exp [6];
        hp_exp = '{3, 6, 3, 6};
`ifdef MOD_SEQ_PINGPONG_EN
        idx_exp = '{0, 1, 2, 1, 0, 1};
`else
        idx_exp = '{0, 1, 2, 0, 1, 2};
`endif
        cfg_bus.valid       = 1'b0;
        cfg_bus.addr        = '0;
        cfg_bus.half_period = '0;
        cfg_bus.dwell       = '0;

        // 1: reset, one-pass sweep of {3,4},{6,2}
        tick(); tick();
        chk_zero("rst");
        rst = 1'b1;
        cfg_wr(0, 3, 4);
        cfg_wr(1, 6, 2);
        kick(2, 1'b0);
        chk("t1_busy_N", busy, 1);
        chk("t1_set_N", mod_set, 0);
        for (int k = 1; k <= 9; k++) begin
            tick();
            chk($sformatf("t1_set_%0d", k), mod_set, 32'(k == 1 || k == 6));
            chk($sformatf("t1_done_%0d", k), done, 32'(k == 8));
            chk($sformatf("t1_busy_%0d", k), busy, 32'(k < 8));
            if (k == 1) chk("t1_hp_1", mod_half_period, 3);
            if (k == 6) chk("t1_hp_6", mod_half_period, 6);
        end

        // 2: looping sweep, then stop mid-dwell
        kick(2, 1'b1);
        nset = 0;
        for (int k = 0; k < 40 && nset < 4; k++) begin
            tick();
            chk("t2_en", mod_enable, 1);
            if (mod_set) begin
                chk($sformatf("t2_hp_%0d", nset), mod_half_period, hp_exp[nset]);
                nset++;
            end
        end
        chk("t2_nset", nset, 4);
        tick();
        stop = 1'b1;
        tick();
        stop = 1'b0;
        chk("t2_stop_en", mod_enable, 0);
        chk("t2_stop_done", done, 0);
        chk("t2_stop_idx", step_idx, 0);
        chk("t2_stop_busy", busy, 0);
        chk("t2_stop_hp", mod_half_period, 6);
        tick();
        chk("t2_stop_done2", done, 0);

        // 3: write stalls while busy; restart ignored while busy
        kick(2, 1'b1);
        tick();
        cfg_bus.valid       = 1'b1;
        cfg_bus.addr        = '0;
        cfg_bus.half_period = PW'(77);
        cfg_bus.dwell       = DW'(5);
        chk("t3_rdy_busy", cfg_bus.ready, 0);
        seq_len = 4'd1;
        start   = 1'b1;
        tick();
        start = 1'b0;
        tick(); tick();
        cfg_bus.valid = 1'b0;
        seen1 = 0;
        for (int k = 0; k < 20; k++) begin
            tick();
            if (mod_set && step_idx == 3'd1) seen1 = 1;
        end
        chk("t3_busy_hold", busy, 1);
        chk("t3_len_kept", seen1, 1);
        stop = 1'b1;
        tick();
        stop = 1'b0;
        kick(1, 1'b0);
        tick();
        chk("t3_table_kept", mod_half_period, 3);
        for (int k = 0; k < 12 && busy; k++) tick();
        chk("t3_idle", busy, 0);
        kick(0, 1'b0);
        chk("t3_len0", busy, 0);
        kick(9, 1'b0);
        chk("t3_len9", busy, 0);

        // 4: same-cycle write+start, zero dwell
        cfg_bus.valid       = 1'b1;
        cfg_bus.addr        = '0;
        cfg_bus.half_period = PW'(9);
        cfg_bus.dwell       = DW'(0);
        seq_len   = 4'd2;
        loop_mode = 1'b0;
        start     = 1'b1;
        tick();
        cfg_bus.valid = 1'b0;
        start         = 1'b0;
        for (int k = 1; k <= 6; k++) begin
            tick();
            chk($sformatf("t4_set_%0d", k), mod_set, 32'(k == 1 || k == 3));
            chk($sformatf("t4_done_%0d", k), done, 32'(k == 5));
            if (k == 1) chk("t4_hp_1", mod_half_period, 9);
            if (k == 3) chk("t4_hp_3", mod_half_period, 6);
        end

        // 5: three-step loop index order
        cfg_wr(2, 20, 1);
        kick(3, 1'b1);
        nset = 0;
        for (int k = 0; k < 60 && nset < 6; k++) begin
            tick();
            if (mod_set) begin
                chk($sformatf("t5_idx_%0d", nset), step_idx, idx_exp[nset]);
                nset++;
            end
        end
        chk("t5_nset", nset, 6);

        // 6: reset mid-dwell, then replay old table
        tick();
        rst = 1'b0;
        tick();
        chk_zero("t6_rst");
        rst = 1'b1;
        kick(2, 1'b0);
        tick();
        chk("t6_hp_1", mod_half_period, 9);
        hp2 = 0;
        saw_done = 0;
        for (int k = 0; k < 12; k++) begin
            tick();
            if (mod_set) hp2 = int'(mod_half_period);
            if (done) saw_done = 1;
        end
        chk("t6_hp_2", hp2, 6);
        chk("t6_done", saw_done, 1);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
